// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Brief    : Serialises one LSB load/store at a time onto the byte-wide RAM/IO
//            bus. Optional macro MC_IO_STALL_EN holds IO stores while
//            io_buffer_full is set.
// Revision : 1.0
// ============================================================================
`ifndef ADDR_TYPE
`define ADDR_TYPE 31:0
`endif
`ifndef DATA_TYPE
`define DATA_TYPE 31:0
`endif
`ifndef LEN_TYPE
`define LEN_TYPE 1:0
`endif
`ifndef OP_TYPE
`define OP_TYPE 1:0
`endif
`ifndef OP_STORE
`define OP_STORE 2'b01
`endif

module memory_controller (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              lsb_to_mc_ready,
    input  logic [`LEN_TYPE]  lsb_to_mc_len,
    input  logic [`OP_TYPE]   lsb_to_mc_opType,
    input  logic [`ADDR_TYPE] lsb_to_mc_addr,
    input  logic [`DATA_TYPE] lsb_to_mc_data,
    output logic              mc_to_lsb_valid,
    output logic              mc_to_lsb_ld_done,
    output logic              mc_to_lsb_st_done,
    output logic [`DATA_TYPE] mc_to_lsb_result,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [`ADDR_TYPE] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [2:0]  k_q,        k_d;
    logic [1:0]  last_q,     last_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] data_q,     data_d;
    logic        valid_q,    valid_d;
    logic        ld_done_q,  ld_done_d;
    logic        st_done_q,  st_done_d;
    logic        mem_wr_q,   mem_wr_d;
    logic [31:0] result_q,   result_d;
    logic [31:0] mem_a_q,    mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;

    logic [1:0]  w_req_last;
    logic        w_req_store;
    logic [1:0]  w_st_tgt;
    logic [1:0]  w_ld_idx;
    logic [2:0]  w_ld_end;
    logic        w_stall_new;
    logic        w_stall_cur;

    always_comb begin
        case (lsb_to_mc_len)
            2'b10:   w_req_last = 2'd1;
            2'b11:   w_req_last = 2'd3;
            default: w_req_last = 2'd0;
        endcase
    end

    assign w_req_store = (lsb_to_mc_opType == `OP_STORE);
    // Store target: advance past a byte that went out, retry one that stalled.
    assign w_st_tgt    = k_q[1:0] + {1'b0, mem_wr_q};
    // Load: k counts cycles in LOAD; the byte arriving now belongs to k-1.
    assign w_ld_idx    = k_q[1:0] - 2'd1;
    assign w_ld_end    = {1'b0, last_q} + 3'd1;

`ifdef MC_IO_STALL_EN
    assign w_stall_new = (lsb_to_mc_addr[17:16] == 2'b11) && io_buffer_full;
    assign w_stall_cur = (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full;
    assign w_stall_new = 1'b0;
    assign w_stall_cur = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        last_d     = last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ld_done_d  = 1'b0;
        st_done_d  = 1'b0;
        mem_wr_d   = mem_wr_q;
        result_d   = result_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;

        case (state_q)
            S_IDLE: begin
                mem_wr_d = 1'b0;
                if (lsb_to_mc_ready && !clr_in && !ld_done_q && !st_done_q) begin
                    addr_d  = lsb_to_mc_addr;
                    data_d  = lsb_to_mc_data;
                    last_d  = w_req_last;
                    valid_d = 1'b1;
                    mem_a_d = lsb_to_mc_addr;
                    k_d     = 3'd0;
                    if (w_req_store) begin
                        state_d    = S_STORE;
                        mem_dout_d = lsb_to_mc_data[7:0];
                        mem_wr_d   = !w_stall_new;
                    end else begin
                        state_d  = S_LOAD;
                        result_d = 32'd0;
                    end
                end
            end

            S_LOAD: begin
                mem_wr_d = 1'b0;
                if (clr_in) begin
                    state_d = S_IDLE;
                end else begin
                    if (k_q != 3'd0) begin
                        result_d[{w_ld_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (k_q == w_ld_end) begin
                        ld_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        k_d = k_q + 3'd1;
                        if (k_q < {1'b0, last_q}) begin
                            mem_a_d = addr_q + {29'd0, k_q} + 32'd1;
                        end
                    end
                end
            end

            S_STORE: begin
                // clr_in is deliberately not looked at: a committed store always finishes.
                if (mem_wr_q && (k_q[1:0] == last_q)) begin
                    st_done_d = 1'b1;
                    mem_wr_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    k_d        = {1'b0, w_st_tgt};
                    mem_a_d    = addr_q + {30'd0, w_st_tgt};
                    mem_dout_d = data_q[{w_st_tgt, 3'b000} +: 8];
                    mem_wr_d   = !w_stall_cur;
                end
            end

            default: begin
                state_d  = S_IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            k_q        <= 3'd0;
            last_q     <= 2'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            valid_q    <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            result_q   <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            k_q        <= k_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            mem_wr_q   <= mem_wr_d;
            result_q   <= result_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    assign mc_to_lsb_valid   = valid_q;
    assign mc_to_lsb_ld_done = ld_done_q;
    assign mc_to_lsb_st_done = st_done_q;
    assign mc_to_lsb_result  = result_q;
    assign mem_a             = mem_a_q;
    assign mem_dout          = mem_dout_q;
    assign mem_wr            = mem_wr_q;

endmodule

`default_nettype wire
